// File: rtl/i2s_rx_pkg.sv
// i2s_rx_pkg: shared state encoding and widths for the I2S receive path
package i2s_rx_pkg;
  localparam int PAIR_W      = 32;
  localparam int SYNC_STAGES = 2;
  typedef enum logic [2:0] {IDLE, WAIT_WS, SKIP, SHIFT, PAD} state_e;
endpackage

// File: rtl/i2s_rx_fifo.sv
// i2s_rx_fifo: synchronous first-word-fall-through buffer of stereo pairs with level and drop flag
module i2s_rx_fifo
  import i2s_rx_pkg::*;
#(
  parameter int FIFO_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [PAIR_W-1:0] data_i,
  output logic [PAIR_W-1:0] data_o,
  output logic [FIFO_AW:0]  lvl_o,
  output logic              empty_o,
  output logic              ovf_o
);
  logic [PAIR_W-1:0] mem_q [2**FIFO_AW];
  logic [FIFO_AW-1:0] wr_q, rd_q;
  logic [FIFO_AW:0] lvl_q;
  logic full, do_push, do_pop;
  assign full    = lvl_q[FIFO_AW];
  assign empty_o = lvl_q == '0;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & ~flush_i & (~full | do_pop);
  assign ovf_o   = push_i & ~flush_i & ~do_push;
  assign data_o  = empty_o ? '0 : mem_q[rd_q];
  assign lvl_o   = lvl_q;
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + FIFO_AW'(1);
      if (do_pop) rd_q <= rd_q + FIFO_AW'(1);
      lvl_q <= lvl_q + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/i2s_rx_deserializer.sv
// i2s_rx_deserializer: oversampled Philips I2S receiver packing {L,R} pairs into a FWFT buffer
module i2s_rx_deserializer
  import i2s_rx_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int FIFO_AW  = 3
) (
  input  logic              WB_CLK,
  input  logic              WB_RST,
  input  logic              rx_en_i,
  input  logic              I2S_CLK_i,
  input  logic              I2S_WS_CLK_i,
  input  logic              I2S_DIN_i,
  output logic [PAIR_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic [FIFO_AW:0]  fifo_lvl_o,
  output logic              ovf_o,
  output logic              sync_err_o,
  input  logic              err_clr_i
);
  localparam int CW = $clog2(SAMPLE_W);
  localparam int SH = 16 - SAMPLE_W;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_W - 1);
  state_e state_q;
  logic [SYNC_STAGES-1:0] bclk_s_q, ws_s_q, din_s_q;
  logic bclk_prev_q, rise_q, ws_q, din_q, ws_prev_q, ws_seen_q;
  logic ch_q, have_l_q, push_q, ovf_q, sync_err_q, ovf_d, sync_err_d;
  logic [CW-1:0] cnt_q;
  logic [SAMPLE_W-1:0] sr_q, left_q, word;
  logic [PAIR_W-1:0] pair_q;
  logic rise, ws_chg, last_bit, short_word, fifo_ovf, empty;
  assign rise       = bclk_s_q[SYNC_STAGES-1] & ~bclk_prev_q;
  assign word       = {sr_q[SAMPLE_W-2:0], din_q};
  assign ws_chg     = rise_q & ws_seen_q & (ws_q != ws_prev_q);
  assign last_bit   = cnt_q == LAST;
  assign short_word = rx_en_i & (state_q == SHIFT) & ws_chg & ~last_bit;
  assign ovf_d      = fifo_ovf | (ovf_q & ~err_clr_i);
  assign sync_err_d = short_word | (sync_err_q & ~err_clr_i);
  assign ovf_o      = ovf_q;
  assign sync_err_o = sync_err_q;
  assign rx_valid_o = ~empty;
  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      bclk_s_q    <= '0;
      ws_s_q      <= '0;
      din_s_q     <= '0;
      bclk_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      ws_q        <= 1'b0;
      din_q       <= 1'b0;
      ws_prev_q   <= 1'b0;
      ws_seen_q   <= 1'b0;
    end else begin
      bclk_s_q    <= {bclk_s_q[SYNC_STAGES-2:0], I2S_CLK_i};
      ws_s_q      <= {ws_s_q[SYNC_STAGES-2:0], I2S_WS_CLK_i};
      din_s_q     <= {din_s_q[SYNC_STAGES-2:0], I2S_DIN_i};
      bclk_prev_q <= bclk_s_q[SYNC_STAGES-1];
      rise_q      <= rise;
      if (rise) begin
        ws_q  <= ws_s_q[SYNC_STAGES-1];
        din_q <= din_s_q[SYNC_STAGES-1];
      end
      if (rise_q) begin
        ws_prev_q <= ws_q;
        ws_seen_q <= 1'b1;
      end
    end
  end
  always_ff @(posedge WB_CLK) begin
    push_q <= 1'b0;
    if (WB_RST || !rx_en_i) begin
      state_q  <= IDLE;
      ch_q     <= 1'b0;
      have_l_q <= 1'b0;
      cnt_q    <= '0;
      sr_q     <= '0;
      left_q   <= '0;
      if (WB_RST) pair_q <= '0;
    end else begin
      case (state_q)
        IDLE: state_q <= WAIT_WS;
        WAIT_WS, PAD: if (ws_chg) begin
          state_q <= SKIP;
          ch_q    <= ws_q;
        end
        SKIP: begin
          state_q <= SHIFT;
          cnt_q   <= '0;
        end
        SHIFT: if (rise_q) begin
          sr_q  <= word;
          cnt_q <= cnt_q + CW'(1);
          if (ws_chg) ch_q <= ws_q;
          if (last_bit) begin
            state_q <= ws_chg ? SKIP : PAD;
            if (!ch_q) begin
              left_q   <= word;
              have_l_q <= 1'b1;
            end else begin
              have_l_q <= 1'b0;
              push_q   <= have_l_q;
              pair_q   <= {16'(left_q) << SH, 16'(word) << SH};
            end
          end else if (ws_chg) begin
            state_q  <= SKIP;
            have_l_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      ovf_q      <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      ovf_q      <= ovf_d;
      sync_err_q <= sync_err_d;
    end
  end
  i2s_rx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk     (WB_CLK),
    .rst     (WB_RST),
    .flush_i (~rx_en_i),
    .push_i  (push_q),
    .pop_i   (rx_ready_i),
    .data_i  (pair_q),
    .data_o  (rx_data_o),
    .lvl_o   (fifo_lvl_o),
    .empty_o (empty),
    .ovf_o   (fifo_ovf)
  );
endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// tb_i2s_rx_deserializer: frame-level pair model with directed I2S frames and literal spot checks
module tb_i2s_rx_deserializer;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst = 1'b1, rx_en = 1'b0, bclk = 1'b0, ws = 1'b1, din = 1'b0;
  logic ready = 1'b0, err_clr = 1'b0;
  logic [31:0] rx_data;
  logic rx_valid, ovf, sync_err;
  logic [3:0] lvl;
  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  event r_lsb_ev;
  always #5 clk = ~clk;
  i2s_rx_deserializer dut (
    .WB_CLK       (clk),
    .WB_RST       (rst),
    .rx_en_i      (rx_en),
    .I2S_CLK_i    (bclk),
    .I2S_WS_CLK_i (ws),
    .I2S_DIN_i    (din),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .rx_ready_i   (ready),
    .fifo_lvl_o   (lvl),
    .ovf_o        (ovf),
    .sync_err_o   (sync_err),
    .err_clr_i    (err_clr)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  task automatic model_pair(input logic [15:0] l, input logic [15:0] r);
    if (exp_q.size() < DEPTH) exp_q.push_back({l, r});
  endtask
  always @(negedge clk) begin
    #1;
    if (!rst && rx_valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_word: got %h expected none", rx_data);
      end else check("pop_data", rx_data, exp_q.pop_front());
    end
  end
  task automatic send_bit(input logic w, input logic b, input bit mark);
    @(negedge clk);
    bclk = 1'b0;
    ws   = w;
    din  = b;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    if (mark) -> r_lsb_ev;
    repeat (3) @(negedge clk);
  endtask
  task automatic send_slot(input logic ch, input logic [31:0] data, input int n);
    for (int i = 0; i < n; i++) send_bit((i == n - 1) ? ~ch : ch, data[31-i], ch && i == 15);
  endtask
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int ln = 32);
    send_slot(1'b0, {l, 16'h5A5A}, ln);
    send_slot(1'b1, {r, 16'hC3C3}, 32);
  endtask
  task automatic expect_push(input logic [31:0] d);
    @(r_lsb_ev);
    repeat (4) @(negedge clk);
    #1 check("latency_pre", 32'(rx_valid), 32'd0);
    @(negedge clk);
    #1 check("latency_valid", 32'(rx_valid), 32'd1);
    check("push_data", rx_data, d);
  endtask
  task automatic pulse_at_push(input logic do_pop, input logic do_clr);
    @(r_lsb_ev);
    repeat (4) @(negedge clk);
    ready   = do_pop;
    err_clr = do_clr;
    @(negedge clk);
    ready   = 1'b0;
    err_clr = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    rst   = 1'b0;
    rx_en = 1'b1;
    #1 check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_lvl", 32'(lvl), 32'd0);
    check("rst_data", rx_data, 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);
    ready = 1'b1;
    send_slot(1'b1, 32'd0, 32);
    model_pair(16'hA5C3, 16'h0F0F);
    fork
      send_frame(16'hA5C3, 16'h0F0F);
      expect_push(32'hA5C30F0F);
    join
    check("sync_err_clean", 32'(sync_err), 32'd0);
    send_frame(16'hFFFF, 16'hEEEE, 10);
    check("sync_err_short", 32'(sync_err), 32'd1);
    check("short_no_push", 32'(lvl), 32'd0);
    model_pair(16'h1234, 16'h5678);
    fork
      send_frame(16'h1234, 16'h5678);
      expect_push(32'h12345678);
    join
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      model_pair(16'(16'h3000 + k), 16'(16'h4000 + k));
      send_frame(16'(16'h3000 + k), 16'(16'h4000 + k));
    end
    check("lvl_three", 32'(lvl), 32'd3);
    fork
      send_frame(16'hDEAD, 16'hBEEF);
      begin
        repeat (70) @(negedge clk);
        rx_en = 1'b0;
        @(negedge clk);
        rx_en = 1'b1;
        exp_q.delete();
        #1 check("flush_lvl", 32'(lvl), 32'd0);
        check("flush_valid", 32'(rx_valid), 32'd0);
        check("flush_keeps_flag", 32'(sync_err), 32'd1);
      end
    join
    ready = 1'b1;
    model_pair(16'h5555, 16'hAAAA);
    send_frame(16'h5555, 16'hAAAA);
    repeat (10) @(negedge clk);
    check("reenable_drained", exp_q.size(), 32'd0);
    ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      model_pair(16'(16'h6000 + k), 16'(16'h7000 + k));
      send_frame(16'(16'h6000 + k), 16'(16'h7000 + k));
    end
    check("ovf_lvl", 32'(lvl), 32'd8);
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_valid", 32'(rx_valid), 32'd1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1 check("clr_ovf", 32'(ovf), 32'd0);
    check("clr_sync_err", 32'(sync_err), 32'd0);
    fork
      send_frame(16'h6009, 16'h7009);
      begin
        pulse_at_push(1'b1, 1'b0);
        model_pair(16'h6009, 16'h7009);
      end
    join
    check("pushpop_no_ovf", 32'(ovf), 32'd0);
    check("pushpop_lvl", 32'(lvl), 32'd8);
    fork
      send_frame(16'h600A, 16'h700A);
      pulse_at_push(1'b0, 1'b1);
    join
    model_pair(16'h600A, 16'h700A);
    check("ovf_set_wins", 32'(ovf), 32'd1);
    ready = 1'b1;
    for (int i = 0; i < 40 && rx_valid; i++) @(negedge clk);
    #1 check("drain_valid", 32'(rx_valid), 32'd0);
    check("drain_model", exp_q.size(), 32'd0);
    ready = 1'b0;
    send_frame(16'hFFFF, 16'hFFFF, 10);
    model_pair(16'h0101, 16'h0202);
    send_frame(16'h0101, 16'h0202);
    check("pre_rst_lvl", 32'(lvl), 32'd1);
    check("pre_rst_flags", {30'd0, ovf, sync_err}, 32'd3);
    fork
      send_frame(16'h0BAD, 16'hF00D);
      begin
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1 check("mid_rst_valid", 32'(rx_valid), 32'd0);
        check("mid_rst_lvl", 32'(lvl), 32'd0);
        check("mid_rst_data", rx_data, 32'd0);
        check("mid_rst_flags", {30'd0, ovf, sync_err}, 32'd0);
      end
    join
    ready = 1'b1;
    model_pair(16'hCAFE, 16'hBEEF);
    fork
      send_frame(16'hCAFE, 16'hBEEF);
      expect_push(32'hCAFEBEEF);
    join
    check("resync_no_err", 32'(sync_err), 32'd0);
    repeat (10) @(negedge clk);
    check("final_model_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
